// File: rtl/ipix_feeder.sv
// Input-pixel feeder: buffers upstream pixels through a small registered FIFO
// and tags window-group boundaries on the way to the PE input pad.
module ipix_feeder #(
  parameter int DWd       = 8,
  parameter int CfgWd     = 8,
  parameter int FifoDepth = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [CfgWd-1:0] i_conf_Pch,
  input  logic [CfgWd-1:0] i_conf_R,
  input  logic [CfgWd-1:0] i_conf_U,
  input  logic [CfgWd-1:0] i_conf_Tw,
  input  logic             i_gpix_valid,
  output logic             o_gpix_ready,
  input  logic [DWd-1:0]   i_gpix,
  output logic             o_ipix_valid,
  input  logic             i_ipix_ready,
  output logic [DWd-1:0]   o_ipix,
  output logic             o_ipix_zero,
  output logic             o_ipix_last,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err
);
  localparam int W2 = 2 * CfgWd;
  localparam int AW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam int CW = $clog2(FifoDepth + 1);

  typedef enum logic [2:0] {IDLE, FILL, SLIDE, DRAIN, DONE} state_t;
  state_t state;

  logic [CfgWd-1:0] pch, r, u, tw;
  logic [W2-1:0]    fill_sz, slide_sz, tw_w;
  logic [DWd-1:0]   mem [FifoDepth];
  logic [AW-1:0]    wptr, rptr;
  logic [CW-1:0]    cnt;
  logic [W2-1:0]    in_cnt, in_win, out_cnt, out_win;
  logic             in_done;
  logic             full, empty, push, pop, cfg_bad;
  logic [W2-1:0]    in_gsz, out_gsz;
  logic             in_glast, in_wlast, out_glast, out_wlast;

  assign fill_sz  = W2'(pch) * W2'(r);
  assign slide_sz = W2'(pch) * W2'(u);
  assign tw_w     = W2'(tw);

  assign full  = (cnt == CW'(FifoDepth));
  assign empty = (cnt == '0);

  // Input and output sides walk the same group structure independently:
  // first group Pch*R pixels, every later group Pch*U pixels, Tw groups.
  assign in_gsz    = (in_win == '0) ? fill_sz : slide_sz;
  assign out_gsz   = (out_win == '0) ? fill_sz : slide_sz;
  assign in_glast  = (in_cnt == in_gsz - W2'(1));
  assign in_wlast  = (in_win == tw_w - W2'(1));
  assign out_glast = (out_cnt == out_gsz - W2'(1));
  assign out_wlast = (out_win == tw_w - W2'(1));

  assign o_gpix_ready = ((state == FILL) || (state == SLIDE)) && !full && !in_done;
  assign o_ipix_valid = !empty;
  assign o_ipix       = o_ipix_valid ? mem[rptr] : '0;
  assign o_ipix_zero  = o_ipix_valid && (mem[rptr] == '0);
  assign o_ipix_last  = o_ipix_valid && out_glast;

  assign push = i_gpix_valid && o_gpix_ready;
  assign pop  = o_ipix_valid && i_ipix_ready;

  assign cfg_bad = (i_conf_Pch == '0) || (i_conf_R == '0) || (i_conf_Tw == '0) ||
                   (i_conf_U == '0) || (i_conf_U > i_conf_R);

  always_ff @(posedge i_clk)
    if (push) mem[wptr] <= i_gpix;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      pch     <= '0;
      r       <= '0;
      u       <= '0;
      tw      <= '0;
      wptr    <= '0;
      rptr    <= '0;
      cnt     <= '0;
      in_cnt  <= '0;
      in_win  <= '0;
      out_cnt <= '0;
      out_win <= '0;
      in_done <= 1'b0;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
      o_err   <= 1'b0;
    end else begin
      o_done <= 1'b0;
      o_err  <= 1'b0;

      if (push) wptr <= (wptr == AW'(FifoDepth - 1)) ? '0 : wptr + AW'(1);
      if (pop)  rptr <= (rptr == AW'(FifoDepth - 1)) ? '0 : rptr + AW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase

      if (push) begin
        if (in_glast) begin
          in_cnt <= '0;
          in_win <= in_win + W2'(1);
          if (in_wlast) in_done <= 1'b1;
        end else begin
          in_cnt <= in_cnt + W2'(1);
        end
      end

      if (pop) begin
        if (out_glast) begin
          out_cnt <= '0;
          out_win <= out_win + W2'(1);
        end else begin
          out_cnt <= out_cnt + W2'(1);
        end
      end

      case (state)
        IDLE: if (i_start) begin
          pch     <= i_conf_Pch;
          r       <= i_conf_R;
          u       <= i_conf_U;
          tw      <= i_conf_Tw;
          in_cnt  <= '0;
          in_win  <= '0;
          out_cnt <= '0;
          out_win <= '0;
          in_done <= 1'b0;
          if (cfg_bad) begin
            state  <= DONE;
            o_done <= 1'b1;
            o_err  <= 1'b1;
          end else begin
            state  <= FILL;
            o_busy <= 1'b1;
          end
        end
        FILL, SLIDE: begin
          // Outputs trail inputs by at least a cycle, so the final output
          // transfer always lands in DRAIN.
          if (push && in_glast && in_wlast)
            state <= DRAIN;
          else if ((state == FILL) && pop && out_glast && (tw_w > W2'(1)))
            state <= SLIDE;
        end
        DRAIN: if (pop && out_glast && out_wlast) begin
          state  <= DONE;
          o_busy <= 1'b0;
          o_done <= 1'b1;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
